spm_dma: RTL
============

Name: spm_dma

Overview:
- Boot/copy DMA engine that sits directly upstream of the scratchpad memory's bus-side port (port B).
- Acts as a bus master: reads a block of 32-bit words from any bus slave (boot ROM, SDRAM) and writes them into SPM through port B.
- Programmed by the CPU through a 4-register slave interface; raises an interrupt on completion.

Parameters:
- SPM_ADDR_W, 12, SPM word-address width (4096 words).
- WORD_ADDR_W, 30, bus word-address width.
- LEN_W, 13, transfer-length width in words (max 4096).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cfg_cs  in  1  register select
- cfg_we  in  1  register write strobe (qualified by cfg_cs)
- cfg_addr  in  2  0=SRC, 1=DST, 2=LEN, 3=CTRL/STATUS
- cfg_wr_data  in  32  register write data
- cfg_rd_data  out  32  register read data, combinational from cfg_addr
- irq  out  1  level interrupt
- bus_req_  out  1  bus request, active low
- bus_grant_  in  1  bus grant, active low
- bus_addr  out  WORD_ADDR_W  read word address
- bus_as_  out  1  address strobe, active low
- bus_rw  out  1  constant 1 (read)
- bus_rd_data  in  32  read data
- bus_rdy_  in  1  read-data valid, active low
- spm_we  out  1  SPM port B write enable
- spm_addr  out  SPM_ADDR_W  SPM port B address
- spm_wr_data  out  32  SPM port B write data

Behaviour:
- Reset values: all registers 0; bus_req_=1, bus_as_=1, spm_we=0, irq=0, bus_addr=0, spm_addr=0, spm_wr_data=0; state IDLE.
- Registers:
  - SRC[WORD_ADDR_W-1:0], DST[SPM_ADDR_W-1:0], LEN[LEN_W-1:0].
  - Writes to SRC/DST/LEN while busy are ignored.
- CTRL write bits:
  - b0 start: ignored if busy.
  - b1 clear done/aborted: write 1 to clear.
  - b2 abort.
  - b3 ie: stored.
- STATUS read: b0 busy, b1 done, b2 aborted, b3 ie, b[28:16] remaining count.
- irq = done & ie, registered.
- Start with LEN=0: no bus activity; done=1 on the next cycle.
- Start with LEN>0: latch working src/dst/remaining, set busy, go to REQ.
- FSM:
  - IDLE: as described above.
  - REQ: bus_req_=0; on bus_grant_=0 go to ACC.
  - ACC: one cycle, bus_as_=0, bus_addr=src; go to WAIT.
  - WAIT: hold; on bus_rdy_=0, capture bus_rd_data, go to WR.
  - WR: spm_we=1 for exactly one cycle, spm_addr=dst, spm_wr_data=captured word. Then src+1, dst+1, remaining-1. If remaining becomes 0, or abort is pending, go to DONE; otherwise go to ACC. bus_req_ stays 0 between beats.
  - DONE: bus_req_=1, busy=0, set done (or aborted if abort was pending); go to IDLE.
- Latency: minimum 3 cycles per word once granted (ACC, WAIT with rdy in the same cycle, WR).
- Wrap rules: dst wraps modulo 2^SPM_ADDR_W; src wraps modulo 2^WORD_ADDR_W.
- Abort: a pending abort never cancels an issued bus read. The current beat always completes, including its SPM write. Abort written in IDLE is ignored. Abort in REQ goes straight to DONE with aborted=1.
- Grant loss: if grant is lost while in ACC, WAIT or WR, the current beat completes and the FSM returns to REQ.
- Simultaneous CTRL write of start and clear in IDLE: the clear applies first, then the start.
- Reset mid-transfer: returns to IDLE immediately, releases the bus, and writes nothing further to SPM.

Decomposition:
- Shared package holds:
  - widths: WordDataBus, WordAddrBus, SpmAddrBus
  - CPU-wide ENABLE/DISABLE and active-low ENABLE_ constants
  - register offsets and CTRL/STATUS bit positions
  - FSM state encodings
- One natural sub-module: spm_dma_regs (register file, STATUS mux, irq generation). The FSM and datapath stay in spm_dma.

Test Plan:
1. SRC=0x100, DST=0x010, LEN=4, ie=1; ROM returns 0xA0..0xA3 with 1-cycle rdy_ -> spm_we pulses at SPM 0x010..0x013 with 0xA0..0xA3; busy falls; done=1; irq=1. Then clear -> irq=0.
2. LEN=0 start -> no bus_req_ assertion; done=1 one cycle later.
3. DST=0xFFE, LEN=3 -> writes to 0xFFE, 0xFFF, 0x000.
4. Abort written while in WAIT with rdy_ delayed 5 cycles -> that word is written; aborted=1, done=0; bus_req_ released; remaining=LEN-1.
5. Grant removed after beat 2 of LEN=4 -> beat 2 completes, FSM re-requests; all 4 words written correctly after re-grant.
6. Reset asserted in WR state -> next cycle spm_we=0, bus_req_=1, all STATUS bits 0.

Source files
------------

// File: rtl/spm_dma_pkg.sv
// Shared widths, bus polarity constants, register map and FSM encodings
// for the scratchpad boot/copy DMA.
package spm_dma_pkg;

  localparam int WordDataBus = 32;
  localparam int WordAddrBus = 30;
  localparam int SpmAddrBus  = 12;
  localparam int LenBus      = 13;

  localparam logic ENABLE   = 1'b1;
  localparam logic DISABLE  = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;
  localparam int CTRL_ABORT = 2;
  localparam int CTRL_IE    = 3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;
  localparam int STAT_IE      = 3;
  localparam int STAT_REM_LSB = 16;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_ACC  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

endpackage

// File: rtl/spm_dma_regs.sv
// CPU-visible register file of the DMA: SRC/DST/LEN, CTRL/STATUS decode,
// sticky done/aborted flags and the registered interrupt.
module spm_dma_regs
  import spm_dma_pkg::*;
#(
  parameter int SPM_ADDR_W  = SpmAddrBus,
  parameter int WORD_ADDR_W = WordAddrBus,
  parameter int LEN_W       = LenBus
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_cs,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_addr,
  input  logic [WordDataBus-1:0] cfg_wr_data,
  output logic [WordDataBus-1:0] cfg_rd_data,
  output logic                   irq,
  input  logic                   busy_i,
  input  logic                   idle_i,
  input  logic [LEN_W-1:0]       rem_i,
  input  logic                   set_done_i,
  input  logic                   set_aborted_i,
  output logic [WORD_ADDR_W-1:0] src_o,
  output logic [SPM_ADDR_W-1:0]  dst_o,
  output logic [LEN_W-1:0]       len_o,
  output logic                   start_o,
  output logic                   abort_o
);

  logic [WORD_ADDR_W-1:0] src_q, src_d;
  logic [SPM_ADDR_W-1:0]  dst_q, dst_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic                   ie_q, ie_d;
  logic                   done_q, done_d;
  logic                   aborted_q, aborted_d;
  logic                   irq_q;

  logic wr_en, ctrl_wr, clear;
  logic unused_wr_bits;

  assign wr_en   = cfg_cs & cfg_we;
  assign ctrl_wr = wr_en && (cfg_addr == REG_CTRL);
  assign clear   = ctrl_wr & cfg_wr_data[CTRL_CLEAR];
  assign start_o = ctrl_wr & cfg_wr_data[CTRL_START] & idle_i;
  assign abort_o = ctrl_wr & cfg_wr_data[CTRL_ABORT] & busy_i;
  assign unused_wr_bits = &{1'b0, cfg_wr_data[WordDataBus-1:WORD_ADDR_W]};

  always_comb begin
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    ie_d      = ie_q;
    done_d    = done_q;
    aborted_d = aborted_q;
    if (wr_en && !busy_i) begin
      if (cfg_addr == REG_SRC) src_d = cfg_wr_data[WORD_ADDR_W-1:0];
      if (cfg_addr == REG_DST) dst_d = cfg_wr_data[SPM_ADDR_W-1:0];
      if (cfg_addr == REG_LEN) len_d = cfg_wr_data[LEN_W-1:0];
    end
    if (ctrl_wr) ie_d = cfg_wr_data[CTRL_IE];
    // Clear is applied before any completion event of the same cycle.
    if (clear) begin
      done_d    = DISABLE;
      aborted_d = DISABLE;
    end
    if (set_done_i)    done_d    = ENABLE;
    if (set_aborted_i) aborted_d = ENABLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      ie_q      <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      ie_q      <= ie_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      irq_q     <= done_q & ie_q;
    end
  end

  always_comb begin
    cfg_rd_data = '0;
    case (cfg_addr)
      REG_SRC: cfg_rd_data[WORD_ADDR_W-1:0] = src_q;
      REG_DST: cfg_rd_data[SPM_ADDR_W-1:0]  = dst_q;
      REG_LEN: cfg_rd_data[LEN_W-1:0]       = len_q;
      default: begin
        cfg_rd_data[STAT_BUSY]               = busy_i;
        cfg_rd_data[STAT_DONE]               = done_q;
        cfg_rd_data[STAT_ABORTED]            = aborted_q;
        cfg_rd_data[STAT_IE]                 = ie_q;
        cfg_rd_data[STAT_REM_LSB +: LEN_W]   = rem_i;
      end
    endcase
  end

  assign irq   = irq_q;
  assign src_o = src_q;
  assign dst_o = dst_q;
  assign len_o = len_q;

endmodule

// File: rtl/spm_dma.sv
// Boot/copy DMA: reads words from a bus slave and writes them into the
// scratchpad through port B, one beat at a time (ACC -> WAIT -> WR).
module spm_dma
  import spm_dma_pkg::*;
#(
  parameter int SPM_ADDR_W  = SpmAddrBus,
  parameter int WORD_ADDR_W = WordAddrBus,
  parameter int LEN_W       = LenBus
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_cs,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_addr,
  input  logic [WordDataBus-1:0] cfg_wr_data,
  output logic [WordDataBus-1:0] cfg_rd_data,
  output logic                   irq,
  output logic                   bus_req_,
  input  logic                   bus_grant_,
  output logic [WORD_ADDR_W-1:0] bus_addr,
  output logic                   bus_as_,
  output logic                   bus_rw,
  input  logic [WordDataBus-1:0] bus_rd_data,
  input  logic                   bus_rdy_,
  output logic                   spm_we,
  output logic [SPM_ADDR_W-1:0]  spm_addr,
  output logic [WordDataBus-1:0] spm_wr_data,
  output logic [2:0]             dbg_state
);

  localparam logic [WORD_ADDR_W-1:0] SRC_ONE = 1;
  localparam logic [SPM_ADDR_W-1:0]  DST_ONE = 1;
  localparam logic [LEN_W-1:0]       LEN_ONE = 1;

  logic [2:0]             state_q, state_d;
  logic [WORD_ADDR_W-1:0] src_q, src_d;
  logic [SPM_ADDR_W-1:0]  dst_q, dst_d;
  logic [LEN_W-1:0]       rem_q, rem_d;
  logic [WordDataBus-1:0] data_q, data_d;
  logic                   abort_q, abort_d;
  logic                   glost_q, glost_d;

  logic [WORD_ADDR_W-1:0] cfg_src;
  logic [SPM_ADDR_W-1:0]  cfg_dst;
  logic [LEN_W-1:0]       cfg_len;
  logic start_req, abort_req, set_done, set_aborted, busy, idle;
  logic abort_now, glost_now;

  assign busy = (state_q == S_REQ) || (state_q == S_ACC) ||
                (state_q == S_WAIT) || (state_q == S_WR);
  assign idle = (state_q == S_IDLE);
  assign abort_now = abort_q | abort_req;
  assign glost_now = glost_q | (bus_grant_ != ENABLE_);

  spm_dma_regs #(
    .SPM_ADDR_W (SPM_ADDR_W),
    .WORD_ADDR_W(WORD_ADDR_W),
    .LEN_W      (LEN_W)
  ) u_regs (
    .clk          (clk),
    .reset        (reset),
    .cfg_cs       (cfg_cs),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wr_data  (cfg_wr_data),
    .cfg_rd_data  (cfg_rd_data),
    .irq          (irq),
    .busy_i       (busy),
    .idle_i       (idle),
    .rem_i        (rem_q),
    .set_done_i   (set_done),
    .set_aborted_i(set_aborted),
    .src_o        (cfg_src),
    .dst_o        (cfg_dst),
    .len_o        (cfg_len),
    .start_o      (start_req),
    .abort_o      (abort_req)
  );

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    rem_d       = rem_q;
    data_d      = data_q;
    abort_d     = abort_now;
    glost_d     = glost_q;
    set_done    = DISABLE;
    set_aborted = DISABLE;
    case (state_q)
      S_IDLE: begin
        abort_d = DISABLE;
        if (start_req) begin
          if (cfg_len == '0) begin
            set_done = ENABLE;
          end else begin
            src_d   = cfg_src;
            dst_d   = cfg_dst;
            rem_d   = cfg_len;
            glost_d = DISABLE;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        glost_d = DISABLE;
        if (abort_now)                  state_d = S_DONE;
        else if (bus_grant_ == ENABLE_) state_d = S_ACC;
      end
      S_ACC: begin
        glost_d = glost_now;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        glost_d = glost_now;
        if (bus_rdy_ == ENABLE_) begin
          data_d  = bus_rd_data;
          state_d = S_WR;
        end
      end
      S_WR: begin
        src_d = src_q + SRC_ONE;
        dst_d = dst_q + DST_ONE;
        rem_d = rem_q - LEN_ONE;
        // An issued read always finishes; abort and grant loss only steer the next beat.
        if ((rem_q == LEN_ONE) || abort_now) state_d = S_DONE;
        else if (glost_now)                  state_d = S_REQ;
        else                                 state_d = S_ACC;
      end
      S_DONE: begin
        if (abort_q) set_aborted = ENABLE;
        else         set_done    = ENABLE;
        abort_d = DISABLE;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      abort_q <= 1'b0;
      glost_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      abort_q <= abort_d;
      glost_q <= glost_d;
    end
  end

  assign bus_req_    = busy ? ENABLE_ : DISABLE_;
  assign bus_as_     = (state_q == S_ACC) ? ENABLE_ : DISABLE_;
  assign bus_rw      = ENABLE;
  assign bus_addr    = src_q;
  assign spm_we      = (state_q == S_WR);
  assign spm_addr    = dst_q;
  assign spm_wr_data = data_q;
  assign dbg_state   = state_q;

endmodule
